// File: rtl/apb4_mem_slave.sv
// APB4 scratchpad slave: parametrised width/depth, optional wait states,
// byte-lane writes, a read-only low region and error reporting.
module apb4_mem_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_LOG2  = 5,
    parameter int WAIT_STATES = 0,
    parameter int RO_WORDS    = 0
) (
    input  logic                    pclk_i,
    input  logic                    preset_i,
    input  logic                    psel_i,
    input  logic                    penable_i,
    input  logic [ADDR_WIDTH-1:0]   paddr_i,
    input  logic                    pwrite_i,
    input  logic [DATA_WIDTH-1:0]   pwdata_i,
    input  logic [DATA_WIDTH/8-1:0] pstrb_i,
    output logic [DATA_WIDTH-1:0]   prdata_o,
    output logic                    pready_o,
    output logic                    pslverr_o
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << LSB) - 1);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_e;

    state_e                  state_q;
    logic [3:0]              cnt_q;
    logic                    err_q;
    logic                    write_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0]   idx;
    logic [DEPTH_LOG2-1:0]   memIdx;
    logic                    misaligned;
    logic                    outOfRange;
    logic                    protectedHit;
    logic                    accessErr;
    logic                    completing;
    logic                    memWe;

    // The mask is all-zero for byte-wide data, which disables the alignment check.
    always_comb begin
        idx          = paddr_i >> LSB;
        memIdx       = idx[DEPTH_LOG2-1:0];
        misaligned   = (paddr_i & ALIGN_MASK) != '0;
        outOfRange   = idx >= ADDR_WIDTH'(DEPTH);
        protectedHit = pwrite_i && (idx < ADDR_WIDTH'(RO_WORDS));
        accessErr    = misaligned || outOfRange || protectedHit;
        completing   = (state_q == ACCESS) && (cnt_q == 4'd0);
        memWe        = !preset_i && completing && psel_i && penable_i && pwrite_i && !err_q;
    end

    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            write_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (psel_i && !penable_i) begin
                        state_q <= ACCESS;
                        cnt_q   <= 4'(WAIT_STATES);
                        err_q   <= accessErr;
                        write_q <= pwrite_i;
                        rdata_q <= (!pwrite_i && !accessErr) ? mem_q[memIdx] : '0;
                    end
                end
                ACCESS: begin
                    if (!psel_i || cnt_q == 4'd0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Memory has no reset; only enabled byte lanes of an error-free write change.
    always_ff @(posedge pclk_i) begin
        if (memWe) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (pstrb_i[b]) begin
                    mem_q[memIdx][8*b +: 8] <= pwdata_i[8*b +: 8];
                end
            end
        end
    end

    assign pready_o  = completing;
    assign pslverr_o = completing && err_q;
    assign prdata_o  = (completing && !write_q) ? rdata_q : '0;

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Randomised bench for apb4_mem_slave: two instances (no wait/RO=2, 3 waits/RO=0)
// checked against a word-array reference model with known-word tracking.
module tb_apb4_mem_slave;

    localparam int WS0 = 0;
    localparam int RO0 = 2;
    localparam int WS1 = 3;
    localparam int RO1 = 0;
    localparam int NWORDS = 32;

    logic        pclk = 1'b0;
    logic        preset  [2];
    logic        psel    [2];
    logic        penable [2];
    logic [31:0] paddr   [2];
    logic        pwrite  [2];
    logic [31:0] pwdata  [2];
    logic [3:0]  pstrb   [2];
    logic [31:0] prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];

    logic [31:0] modelMem [2][NWORDS];
    bit          known    [2][NWORDS];

    int checkCount = 0;
    int errorCount = 0;

    always #5 pclk = ~pclk;

    apb4_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(5),
                     .WAIT_STATES(WS0), .RO_WORDS(RO0)) dut0 (
        .pclk_i(pclk), .preset_i(preset[0]), .psel_i(psel[0]), .penable_i(penable[0]),
        .paddr_i(paddr[0]), .pwrite_i(pwrite[0]), .pwdata_i(pwdata[0]), .pstrb_i(pstrb[0]),
        .prdata_o(prdata[0]), .pready_o(pready[0]), .pslverr_o(pslverr[0])
    );

    apb4_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(5),
                     .WAIT_STATES(WS1), .RO_WORDS(RO1)) dut1 (
        .pclk_i(pclk), .preset_i(preset[1]), .psel_i(psel[1]), .penable_i(penable[1]),
        .paddr_i(paddr[1]), .pwrite_i(pwrite[1]), .pwdata_i(pwdata[1]), .pstrb_i(pstrb[1]),
        .prdata_o(prdata[1]), .pready_o(pready[1]), .pslverr_o(pslverr[1])
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic idleCycle(input int d);
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
        @(posedge pclk); #1;
    endtask

    // One full APB transfer; expectations come from the address rules and the model.
    task automatic applyStimulus(input int d, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] strb,
                                 output logic [31:0] rdataObs, output logic errObs);
        int  waits;
        int  idx;
        int  ws;
        int  ro;
        bit  expErr;
        ws     = (d == 0) ? WS0 : WS1;
        ro     = (d == 0) ? RO0 : RO1;
        idx    = int'(addr >> 2);
        expErr = (addr[1:0] != 2'b00) || (idx >= NWORDS) || (wr && idx < ro);

        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        paddr[d]   = addr;
        pwrite[d]  = wr;
        pwdata[d]  = wdata;
        pstrb[d]   = strb;
        checkOutput("setupReady", 64'(pready[d]), 64'd0);
        @(posedge pclk); #1;
        penable[d] = 1'b1;

        waits = 0;
        while (pready[d] !== 1'b1 && waits <= 20) begin
            checkOutput("waitSlverr", 64'(pslverr[d]), 64'd0);
            @(posedge pclk); #1;
            waits++;
        end
        checkOutput("latency", 64'(waits), 64'(ws));
        checkOutput("slverr", 64'(pslverr[d]), 64'(expErr));
        rdataObs = prdata[d];
        errObs   = pslverr[d];
        if (wr || expErr) begin
            checkOutput("rdataZero", 64'(prdata[d]), 64'd0);
        end else if (known[d][idx]) begin
            checkOutput("rdata", 64'(prdata[d]), 64'(modelMem[d][idx]));
        end

        @(posedge pclk); #1;
        if (wr && !expErr) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) modelMem[d][idx][8*b +: 8] = wdata[8*b +: 8];
            end
            if (strb == 4'hF) known[d][idx] = 1'b1;
        end
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] addr;

        for (int d = 0; d < 2; d++) begin
            preset[d] = 1'b1; psel[d] = 1'b0; penable[d] = 1'b0; paddr[d] = '0;
            pwrite[d] = 1'b0; pwdata[d] = '0; pstrb[d] = '0;
            for (int w = 0; w < NWORDS; w++) known[d][w] = 1'b0;
        end
        repeat (3) @(posedge pclk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checkOutput("resetReady", 64'(pready[d]), 64'd0);
            checkOutput("resetSlverr", 64'(pslverr[d]), 64'd0);
            checkOutput("resetRdata", 64'(prdata[d]), 64'd0);
            preset[d] = 1'b0;
        end

        // Fill every writable word so later reads have known contents
        for (int d = 0; d < 2; d++) begin
            for (int w = (d == 0 ? RO0 : RO1); w < NWORDS; w++) begin
                applyStimulus(d, 1'b1, 32'(w * 4), $urandom, 4'hF, rd, er);
            end
        end

        applyStimulus(0, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF, rd, er);
        applyStimulus(0, 1'b0, 32'h8, 32'h0, 4'h0, rd, er);
        checkOutput("deadbeef", 64'(rd), 64'hDEADBEEF);

        applyStimulus(1, 1'b1, 32'h4, 32'h11223344, 4'hF, rd, er);
        applyStimulus(1, 1'b1, 32'h4, 32'hAABBCCDD, 4'b0101, rd, er);
        applyStimulus(1, 1'b0, 32'h4, 32'h0, 4'h0, rd, er);
        checkOutput("strobeMerge", 64'(rd), 64'h11BB33DD);

        applyStimulus(0, 1'b0, 32'h80, 32'h0, 4'h0, rd, er);
        checkOutput("rangeErr", 64'(er), 64'd1);
        applyStimulus(0, 1'b1, 32'h6, 32'h12345678, 4'hF, rd, er);
        checkOutput("misalignErr", 64'(er), 64'd1);
        applyStimulus(0, 1'b1, 32'hA, 32'h12345678, 4'hF, rd, er);
        applyStimulus(0, 1'b0, 32'h8, 32'h0, 4'h0, rd, er);
        checkOutput("misalignNoWrite", 64'(rd), 64'hDEADBEEF);
        applyStimulus(0, 1'b1, 32'h4, 32'h12345678, 4'hF, rd, er);
        checkOutput("protectErr", 64'(er), 64'd1);
        applyStimulus(0, 1'b0, 32'h4, 32'h0, 4'h0, rd, er);
        checkOutput("protectRead", 64'(er), 64'd0);
        applyStimulus(0, 1'b1, 32'h10, 32'hCAFEF00D, 4'h0, rd, er);
        checkOutput("strbZeroErr", 64'(er), 64'd0);

        // Back-to-back: no idle gap between write and read
        applyStimulus(0, 1'b1, 32'h10, 32'h5A5A1234, 4'hF, rd, er);
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er);
        checkOutput("b2bRead", 64'(rd), 64'h5A5A1234);
        applyStimulus(1, 1'b1, 32'h10, 32'h0BADF00D, 4'hF, rd, er);
        applyStimulus(1, 1'b0, 32'h10, 32'h0, 4'h0, rd, er);
        checkOutput("b2bReadWs", 64'(rd), 64'h0BADF00D);
        idleCycle(1);

        // Reset in the middle of a waited write must leave the target word alone
        psel[1] = 1'b1; penable[1] = 1'b0; paddr[1] = 32'h40; pwrite[1] = 1'b1;
        pwdata[1] = ~modelMem[1][16]; pstrb[1] = 4'hF;
        @(posedge pclk); #1;
        penable[1] = 1'b1;
        @(posedge pclk); #1;
        checkOutput("midReady", 64'(pready[1]), 64'd0);
        preset[1] = 1'b1;
        @(posedge pclk); #1;
        checkOutput("abortReady", 64'(pready[1]), 64'd0);
        checkOutput("abortSlverr", 64'(pslverr[1]), 64'd0);
        checkOutput("abortRdata", 64'(prdata[1]), 64'd0);
        preset[1] = 1'b0; psel[1] = 1'b0; penable[1] = 1'b0;
        @(posedge pclk); #1;
        applyStimulus(1, 1'b0, 32'h40, 32'h0, 4'h0, rd, er);
        checkOutput("abortNoWrite", 64'(rd), 64'(modelMem[1][16]));

        for (int i = 0; i < 240; i++) begin
            int d;
            d    = i % 2;
            addr = 32'($urandom_range(0, 36 * 4 - 1));
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            applyStimulus(d, 1'($urandom_range(0, 1)), addr, $urandom,
                          4'($urandom_range(0, 15)), rd, er);
            if ($urandom_range(0, 4) == 0) idleCycle(d);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
